sound_event_scheduler: RTL and testbench

- Arbitrates and sequences the single game speaker between three game-logic requesters: paddle hit, wall bounce and score.
- Sits between the game logic and the `Speaker` pin, inside the sound-enabled game block.
- Latches one-cycle event pulses and grants the speaker by fixed priority.
- Times each tone and generates the square wave; a score plays a two-note sequence.

---
 rtl/sound_pkg.sv | 16 +
 rtl/tone_divider.sv | 31 +++
 rtl/sound_event_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sound_event_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types for the speaker scheduler: sequencing states, event codes
// and the counter widths every timer in the block is sized against.
package sound_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, GAP, PLAY2} state_t;

   localparam logic [1:0] EV_NONE   = 2'd0;
   localparam logic [1:0] EV_WALL   = 2'd1;
   localparam logic [1:0] EV_PADDLE = 2'd2;
   localparam logic [1:0] EV_SCORE  = 2'd3;

   localparam int HALF_W = 18;
   localparam int PRE_W  = 17;
   localparam int TICK_W = 8;

endpackage

// File: rtl/tone_divider.sv
// Loadable half-period counter driving a toggle flop; the flop is held low
// whenever the divider is disabled or being (re)loaded.
module tone_divider
   import sound_pkg::*;
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              enable,
   input  logic              load,
   input  logic [HALF_W-1:0] half_period,
   output logic              wave
);

   logic [HALF_W-1:0] cnt;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (load || !enable) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (cnt == half_period - 1'b1) begin
         cnt  <= '0;
         wave <= ~wave;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sound_event_scheduler.sv
// Fixed-priority arbiter and sequencer for the single game speaker:
// latches request pulses, times each tone and drives the square wave.
module sound_event_scheduler
   import sound_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned PADDLE_HALF  = 113636,
   parameter int unsigned WALL_HALF    = 227272,
   parameter int unsigned SCORE_HALF1  = 56818,
   parameter int unsigned SCORE_HALF2  = 113636,
   parameter int unsigned PADDLE_TICKS = 50,
   parameter int unsigned WALL_TICKS   = 30,
   parameter int unsigned SCORE_TICKS  = 150,
   parameter int unsigned GAP_TICKS    = 20
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       paddle_hit,
   input  logic       wall_hit,
   input  logic       score,
   input  logic       mute,
   output logic       Speaker,
   output logic       busy,
   output logic [1:0] active_event
);

   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [HALF_W-1:0] H_PAD    = HALF_W'(PADDLE_HALF);
   localparam logic [HALF_W-1:0] H_WALL   = HALF_W'(WALL_HALF);
   localparam logic [HALF_W-1:0] H_SC1    = HALF_W'(SCORE_HALF1);
   localparam logic [HALF_W-1:0] H_SC2    = HALF_W'(SCORE_HALF2);
   localparam logic [TICK_W-1:0] T_PAD    = TICK_W'(PADDLE_TICKS);
   localparam logic [TICK_W-1:0] T_WALL   = TICK_W'(WALL_TICKS);
   localparam logic [TICK_W-1:0] T_SC     = TICK_W'(SCORE_TICKS);
   localparam logic [TICK_W-1:0] T_GAP    = TICK_W'(GAP_TICKS);

   state_t            state, state_n;
   logic [1:0]        ev, ev_n;
   logic [2:0]        pend, pend_n, req;
   logic [PRE_W-1:0]  pre;
   logic [TICK_W-1:0] tick, lim;
   logic [HALF_W-1:0] half;
   logic              tone_end, load, restart, enable, wave;

   function automatic logic [TICK_W-1:0] ticks_of(input state_t s, input logic [1:0] e);
      if (s == GAP)   return T_GAP;
      if (s == PLAY2) return T_SC;
      case (e)
         EV_WALL:   return T_WALL;
         EV_PADDLE: return T_PAD;
         default:   return T_SC;
      endcase
   endfunction

   function automatic logic [HALF_W-1:0] half_of(input state_t s, input logic [1:0] e);
      if (s == PLAY2) return H_SC2;
      case (e)
         EV_WALL:   return H_WALL;
         EV_PADDLE: return H_PAD;
         default:   return H_SC1;
      endcase
   endfunction

   // req bit index is event code minus one: {score, paddle, wall}
   assign req      = pend | {score, paddle_hit, wall_hit};
   assign lim      = ticks_of(state, ev);
   assign half     = half_of(state, ev);
   assign tone_end = (pre == PRE_LAST) && (tick == lim - 1'b1);

   always_comb begin
      state_n = state;
      ev_n    = ev;
      pend_n  = req;
      load    = 1'b0;
      restart = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n = PLAY;
               load    = 1'b1;
               restart = 1'b1;
               if (req[2]) begin
                  ev_n      = EV_SCORE;
                  pend_n[2] = 1'b0;
               end else if (req[1]) begin
                  ev_n      = EV_PADDLE;
                  pend_n[1] = 1'b0;
               end else begin
                  ev_n      = EV_WALL;
                  pend_n[0] = 1'b0;
               end
            end
         end
         PLAY, GAP, PLAY2: begin
            if (req[2]) begin
               // score during note 1 only extends it; anywhere else it restarts note 1
               pend_n[2] = 1'b0;
               ev_n      = EV_SCORE;
               restart   = 1'b1;
               if (!(state == PLAY && ev == EV_SCORE)) begin
                  state_n = PLAY;
                  load    = 1'b1;
               end
            end else if (req[1] && state == PLAY && ev == EV_WALL) begin
               pend_n[1] = 1'b0;
               ev_n      = EV_PADDLE;
               load      = 1'b1;
               restart   = 1'b1;
            end else if (state == PLAY && ev == EV_PADDLE && req[1]) begin
               pend_n[1] = 1'b0;
               restart   = 1'b1;
            end else if (state == PLAY && ev == EV_WALL && req[0]) begin
               pend_n[0] = 1'b0;
               restart   = 1'b1;
            end else if (tone_end) begin
               if (state == PLAY && ev == EV_SCORE) begin
                  state_n = GAP;
                  restart = 1'b1;
               end else if (state == GAP) begin
                  state_n = PLAY2;
                  load    = 1'b1;
                  restart = 1'b1;
               end else begin
                  state_n = IDLE;
                  ev_n    = EV_NONE;
               end
            end
         end
      endcase
   end

   assign enable = (state_n == PLAY) || (state_n == PLAY2);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         ev    <= EV_NONE;
         pend  <= '0;
      end else begin
         state <= state_n;
         ev    <= ev_n;
         pend  <= pend_n;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pre  <= '0;
         tick <= '0;
      end else if (restart || state_n == IDLE) begin
         pre  <= '0;
         tick <= '0;
      end else if (pre == PRE_LAST) begin
         pre  <= '0;
         tick <= tick + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   tone_divider u_div (
      .Clock      (Clock),
      .Reset      (Reset),
      .enable     (enable),
      .load       (load),
      .half_period(half),
      .wave       (wave)
   );

   assign Speaker      = wave & ~mute;
   assign busy         = (state != IDLE);
   assign active_event = ev;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for the speaker scheduler using small timing parameters;
// checkpoints are relative to the cycle a scenario's first pulse is driven.
module tb_sound_event_scheduler;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       paddle_hit, wall_hit, score, mute;
   logic       Speaker, busy;
   logic [1:0] active_event;

   sound_event_scheduler #(
      .TICK_DIV(4), .PADDLE_HALF(3), .WALL_HALF(5), .SCORE_HALF1(2), .SCORE_HALF2(3),
      .PADDLE_TICKS(4), .WALL_TICKS(3), .SCORE_TICKS(2), .GAP_TICKS(1)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .paddle_hit  (paddle_hit),
      .wall_hit    (wall_hit),
      .score       (score),
      .mute        (mute),
      .Speaker     (Speaker),
      .busy        (busy),
      .active_event(active_event)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string      name;
      bit         go;
      bit         p, w, s, m;
      int         ck;
      logic       spk, bsy;
      logic [1:0] ev;
   } vec_t;

   vec_t tbl[$];
   int   compared = 0;
   int   mismatched = 0;
   int   rel = 0;

   task automatic add(input string nm, input bit go, input bit p, input bit w, input bit s,
                      input bit m, input int ck, input logic spk, input logic bsy,
                      input logic [1:0] ev);
      vec_t v;
      v.name = nm; v.go = go; v.p = p; v.w = w; v.s = s; v.m = m;
      v.ck = ck; v.spk = spk; v.bsy = bsy; v.ev = ev;
      tbl.push_back(v);
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
      rel++;
      paddle_hit = 1'b0;
      wall_hit   = 1'b0;
      score      = 1'b0;
   endtask

   task automatic check(input string nm, input logic spk, input logic bsy, input logic [1:0] ev);
      compared++;
      if (Speaker !== spk || busy !== bsy || active_event !== ev) begin
         mismatched++;
         $display("FAIL %s rel=%0d: got spk=%b busy=%b ev=%0d, expected spk=%b busy=%b ev=%0d",
                  nm, rel, Speaker, busy, active_event, spk, bsy, ev);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         step();
         n++;
      end
      if (busy !== 1'b0) begin
         compared++;
         mismatched++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
      end
   endtask

   initial begin
      bit stray;

      // paddle alone
      add("pad",      1, 1, 0, 0, 0,  0, 0, 0, 0);
      add("pad",      0, 0, 0, 0, 0,  1, 0, 1, 2);
      add("pad",      0, 0, 0, 0, 0,  3, 0, 1, 2);
      add("pad",      0, 0, 0, 0, 0,  4, 1, 1, 2);
      add("pad",      0, 0, 0, 0, 0,  7, 0, 1, 2);
      add("pad",      0, 0, 0, 0, 0, 10, 1, 1, 2);
      add("pad",      0, 0, 0, 0, 0, 16, 1, 1, 2);
      add("pad",      0, 0, 0, 0, 0, 17, 0, 0, 0);
      add("pad",      0, 0, 0, 0, 0, 20, 0, 0, 0);
      // paddle and wall together
      add("simul",    1, 1, 1, 0, 0,  0, 0, 0, 0);
      add("simul",    0, 0, 0, 0, 0,  1, 0, 1, 2);
      add("simul",    0, 0, 0, 0, 0, 16, 1, 1, 2);
      add("simul",    0, 0, 0, 0, 0, 17, 0, 0, 0);
      add("simul",    0, 0, 0, 0, 0, 18, 0, 1, 1);
      add("simul",    0, 0, 0, 0, 0, 22, 0, 1, 1);
      add("simul",    0, 0, 0, 0, 0, 23, 1, 1, 1);
      add("simul",    0, 0, 0, 0, 0, 28, 0, 1, 1);
      add("simul",    0, 0, 0, 0, 0, 29, 0, 1, 1);
      add("simul",    0, 0, 0, 0, 0, 30, 0, 0, 0);
      // two-note score
      add("score",    1, 0, 0, 1, 0,  0, 0, 0, 0);
      add("score",    0, 0, 0, 0, 0,  1, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0,  3, 1, 1, 3);
      add("score",    0, 0, 0, 0, 0,  5, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0,  8, 1, 1, 3);
      add("score",    0, 0, 0, 0, 0,  9, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0, 12, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0, 13, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0, 16, 1, 1, 3);
      add("score",    0, 0, 0, 0, 0, 19, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0, 20, 0, 1, 3);
      add("score",    0, 0, 0, 0, 0, 21, 0, 0, 0);
      // score preempts wall on its 5th cycle
      add("preempt",  1, 0, 1, 0, 0,  0, 0, 0, 0);
      add("preempt",  0, 0, 0, 0, 0,  1, 0, 1, 1);
      add("preempt",  0, 0, 0, 1, 0,  5, 0, 1, 1);
      add("preempt",  0, 0, 0, 0, 0,  6, 0, 1, 3);
      add("preempt",  0, 0, 0, 0, 0,  8, 1, 1, 3);
      add("preempt",  0, 0, 0, 0, 0, 14, 0, 1, 3);
      add("preempt",  0, 0, 0, 0, 0, 25, 0, 1, 3);
      add("preempt",  0, 0, 0, 0, 0, 26, 0, 0, 0);
      add("preempt",  0, 0, 0, 0, 0, 35, 0, 0, 0);
      // muted paddle
      add("mute",     1, 1, 0, 0, 1,  0, 0, 0, 0);
      add("mute",     0, 0, 0, 0, 0,  1, 0, 1, 2);
      add("mute",     0, 0, 0, 0, 0,  4, 0, 1, 2);
      add("mute",     0, 0, 0, 0, 0, 10, 0, 1, 2);
      add("mute",     0, 0, 0, 0, 0, 16, 0, 1, 2);
      add("mute",     0, 0, 0, 0, 0, 17, 0, 0, 0);
      // paddle retrigger keeps phase and extends
      add("retrig",   1, 1, 0, 0, 0,  0, 0, 0, 0);
      add("retrig",   0, 1, 0, 0, 0,  8, 0, 1, 2);
      add("retrig",   0, 0, 0, 0, 0, 10, 1, 1, 2);
      add("retrig",   0, 0, 0, 0, 0, 17, 1, 1, 2);
      add("retrig",   0, 0, 0, 0, 0, 24, 1, 1, 2);
      add("retrig",   0, 0, 0, 0, 0, 25, 0, 0, 0);
      add("retrig",   0, 0, 0, 0, 0, 30, 0, 0, 0);
      // paddle preempts wall
      add("pad_wall", 1, 0, 1, 0, 0,  0, 0, 0, 0);
      add("pad_wall", 0, 1, 0, 0, 0,  2, 0, 1, 1);
      add("pad_wall", 0, 0, 0, 0, 0,  3, 0, 1, 2);
      add("pad_wall", 0, 0, 0, 0, 0,  6, 1, 1, 2);
      add("pad_wall", 0, 0, 0, 0, 0, 18, 1, 1, 2);
      add("pad_wall", 0, 0, 0, 0, 0, 19, 0, 0, 0);
      add("pad_wall", 0, 0, 0, 0, 0, 25, 0, 0, 0);
      // paddle during score waits for IDLE
      add("pending",  1, 0, 0, 1, 0,  0, 0, 0, 0);
      add("pending",  0, 1, 0, 0, 0,  2, 0, 1, 3);
      add("pending",  0, 0, 0, 0, 0, 20, 0, 1, 3);
      add("pending",  0, 0, 0, 0, 0, 21, 0, 0, 0);
      add("pending",  0, 0, 0, 0, 0, 22, 0, 1, 2);
      add("pending",  0, 0, 0, 0, 0, 37, 1, 1, 2);
      add("pending",  0, 0, 0, 0, 0, 38, 0, 0, 0);

      paddle_hit = 1'b0; wall_hit = 1'b0; score = 1'b0; mute = 1'b0;
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      check("reset_state", 1'b0, 1'b0, 2'd0);
      Reset = 1'b0;
      step();
      step();

      foreach (tbl[i]) begin
         if (tbl[i].go) begin
            wait_idle();
            mute = tbl[i].m;
            step();
            step();
            rel = 0;
         end
         while (rel < tbl[i].ck) step();
         check($sformatf("%s@%0d", tbl[i].name, tbl[i].ck), tbl[i].spk, tbl[i].bsy, tbl[i].ev);
         paddle_hit = tbl[i].p;
         wall_hit   = tbl[i].w;
         score      = tbl[i].s;
      end

      // asynchronous reset in the middle of note 2 with a paddle pending
      wait_idle();
      mute = 1'b0;
      step();
      rel = 0;
      score = 1'b1;
      step();
      step();
      paddle_hit = 1'b1;
      while (rel < 17) step();
      check("rst_pre", 1'b1, 1'b1, 2'd3);
      #2 Reset = 1'b1;
      #1 check("rst_async", 1'b0, 1'b0, 2'd0);
      step();
      step();
      Reset = 1'b0;
      stray = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (busy !== 1'b0 || Speaker !== 1'b0) stray = 1'b1;
      end
      compared++;
      if (stray) begin
         mismatched++;
         $display("FAIL rst_no_replay: activity seen after reset release, expected none");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
